// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] s);
        onehot8    = '0;
        onehot8[s] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping modulo 8.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        win = ptr;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!any && req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 8-to-1 datapath mux with a one-entry output register.
// Optional burst lock (grant held until req_last) is enabled by defining MUX_ARB_LOCK_EN.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]    req_last,
`endif
    output logic [N_REQ-1:0]    req_ready,
    output logic [SEL_W-1:0]    sel,
    output logic [N_REQ-1:0]    grant,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic                busy
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win;
    logic             any;
    logic             slot_free;
    logic             accept;
    logic             rel_beat;

    rr_pick8 u_pick (
        .req (req_valid),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    // Ready depends only on state, sel and the output slot, never on req_valid.
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state == GRANT);
    assign req_ready = (busy && slot_free) ? onehot8(sel) : '0;
    assign accept    = busy && slot_free && req_valid[sel];

`ifdef MUX_ARB_LOCK_EN
    assign rel_beat = accept && req_last[sel];
`else
    assign rel_beat = accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                out_data  <= req_data[int'(sel)*DW +: DW];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any) begin
                        sel   <= win;
                        grant <= onehot8(win);
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_beat) begin
                        grant <= '0;
                        ptr   <= sel + SEL_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter; lock scenario runs only with MUX_ARB_LOCK_EN.
module tb_mux8_rr_arbiter;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic [7:0]    req_valid;
    logic [8*DW-1:0] req_data;
    logic [7:0]    req_last;
    logic [7:0]    req_ready;
    logic [2:0]    sel;
    logic [7:0]    grant;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    mux8_rr_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef MUX_ARB_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_data;
        for (int i = 0; i < 8; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        out_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 8'($urandom);
        req_data = {$urandom, $urandom};
        req_last = 8'($urandom);
        out_ready = 1'($urandom);
        #1;
        checks++;
        if ({grant, req_ready, sel, out_valid, out_data, busy} !== '0) begin
            errors++;
            $display("FAIL reset_async: grant=%h ready=%h sel=%0d ov=%b od=%h busy=%b want all 0",
                     grant, req_ready, sel, out_valid, out_data, busy);
        end
        tick;
        tick;
        checks++;
        if ({grant, req_ready, sel, out_valid, out_data, busy} !== '0) begin
            errors++;
            $display("FAIL reset_held: grant=%h ready=%h sel=%0d ov=%b od=%h busy=%b want all 0",
                     grant, req_ready, sel, out_valid, out_data, busy);
        end
        req_valid = '0;
        req_last = '0;
        out_ready = 1'b1;
        fill_data();
        rst_n = 1'b1;
        tick;
        req_valid = 8'h20;
        tick;
        checks++;
        if (sel !== 3'd5 || grant !== 8'h20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: sel=%0d grant=%h busy=%b want sel=5 grant=20 busy=1",
                     sel, grant, busy);
        end
        checks++;
        if (req_ready !== 8'h20) begin
            errors++;
            $display("FAIL reset_first_ready: got %h want 20", req_ready);
        end
        tick;
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || grant !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_beat: ov=%b od=%h grant=%h busy=%b want ov=1 od=a5 grant=00 busy=0",
                     out_valid, out_data, grant, busy);
        end
    endtask

    task automatic test_fairness;
        logic [2:0] es;
        do_reset();
        fill_data();
        req_valid = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            es = 3'(k % 8);
            tick;
            checks++;
            if (grant !== (8'h01 << es) || sel !== es || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fair_grant[%0d]: grant=%h sel=%0d ov=%b want grant=%h sel=%0d ov=0",
                         k, grant, sel, out_valid, 8'h01 << es, es);
            end
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_data !== (8'hA0 + 8'(es)) || grant !== 8'h00) begin
                errors++;
                $display("FAIL fair_beat[%0d]: ov=%b od=%h grant=%h want ov=1 od=%h grant=00",
                         k, out_valid, out_data, grant, 8'hA0 + 8'(es));
            end
        end
        req_valid = '0;
        tick;
    endtask

    task automatic test_wrap;
        do_reset();
        fill_data();
        req_valid = 8'h40;
        tick;
        tick;
        req_valid = 8'h81;
        tick;
        checks++;
        if (grant !== 8'h80 || sel !== 3'd7) begin
            errors++;
            $display("FAIL wrap_first: grant=%h sel=%0d want grant=80 sel=7", grant, sel);
        end
        tick;
        req_valid = 8'h01;
        checks++;
        if (out_data !== 8'hA7) begin
            errors++;
            $display("FAIL wrap_first_data: got %h want a7", out_data);
        end
        tick;
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL wrap_second: grant=%h sel=%0d want grant=01 sel=0", grant, sel);
        end
        tick;
        req_valid = '0;
        checks++;
        if (out_data !== 8'hA0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second_data: od=%h ov=%b want od=a0 ov=1", out_data, out_valid);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        fill_data();
        out_ready = 1'b0;
        req_valid = 8'h02;
        tick;
        tick;
        req_valid = 8'h08;
        tick;
        checks++;
        if (grant !== 8'h08 || req_ready !== 8'h00 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
            errors++;
            $display("FAIL bp_stall: grant=%h ready=%h ov=%b od=%h want grant=08 ready=00 ov=1 od=a1",
                     grant, req_ready, out_valid, out_data);
        end
        tick;
        checks++;
        if (grant !== 8'h08 || req_ready !== 8'h00 || out_data !== 8'hA1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: grant=%h ready=%h od=%h busy=%b want grant=08 ready=00 od=a1 busy=1",
                     grant, req_ready, out_data, busy);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 8'h08) begin
            errors++;
            $display("FAIL bp_ready_comb: got %h want 08", req_ready);
        end
        tick;
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA3 || grant !== 8'h00) begin
            errors++;
            $display("FAIL bp_release: ov=%b od=%h grant=%h want ov=1 od=a3 grant=00",
                     out_valid, out_data, grant);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_lock;
`ifdef MUX_ARB_LOCK_EN
        do_reset();
        fill_data();
        out_ready = 1'b1;
        req_valid = 8'h14;
        req_last = 8'h00;
        tick;
        checks++;
        if (grant !== 8'h04) begin
            errors++;
            $display("FAIL lock_grant: got %h want 04", grant);
        end
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                req_valid = 8'h10;
                tick;
                tick;
                checks++;
                if (grant !== 8'h04 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_gap: grant=%h ov=%b want grant=04 ov=0", grant, out_valid);
                end
                req_valid = 8'h14;
            end
            req_data[2*DW +: DW] = 8'h30 + 8'(b);
            req_last = (b == 3) ? 8'h04 : 8'h00;
            tick;
            checks++;
            if (out_data !== (8'h30 + 8'(b)) || out_valid !== 1'b1 ||
                grant !== ((b == 3) ? 8'h00 : 8'h04)) begin
                errors++;
                $display("FAIL lock_beat[%0d]: od=%h ov=%b grant=%h want od=%h ov=1 grant=%h",
                         b, out_data, out_valid, grant, 8'h30 + 8'(b), (b == 3) ? 8'h00 : 8'h04);
            end
        end
        req_valid = 8'h10;
        req_last = 8'h00;
        tick;
        checks++;
        if (grant !== 8'h10 || sel !== 3'd4) begin
            errors++;
            $display("FAIL lock_next: grant=%h sel=%0d want grant=10 sel=4", grant, sel);
        end
        tick;
        req_valid = '0;
        tick;
`endif
    endtask

    task automatic test_reset_mid;
        do_reset();
        fill_data();
        out_ready = 1'b0;
        req_valid = 8'h10;
        tick;
        tick;
        req_valid = 8'h04;
        tick;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || sel !== 3'd2) begin
            errors++;
            $display("FAIL mid_setup: busy=%b ov=%b sel=%0d want busy=1 ov=1 sel=2", busy, out_valid, sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, req_ready, sel, out_valid, out_data, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset: grant=%h ready=%h sel=%0d ov=%b od=%h busy=%b want all 0",
                     grant, req_ready, sel, out_valid, out_data, busy);
        end
        req_valid = 8'h81;
        out_ready = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL mid_ptr: grant=%h sel=%0d want grant=01 sel=0", grant, sel);
        end
        tick;
        req_valid = '0;
        checks++;
        if (out_data !== 8'hA0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat: od=%h ov=%b want od=a0 ov=1", out_data, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_lock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the shared 8-to-1 datapath mux. Eight requesters each present a data word with a valid/ready handshake. The block grants one requester at a time and drives the 3-bit mux select. It forwards the granted word through a one-entry registered output stage toward a single downstream consumer.

## Interface
Parameters:
- `DW`, 8: data width per requester.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, 8: per-requester valid.
- `req_data`, input, 8*DW: requester i occupies bits [i*DW +: DW].
- `req_last`, input, 8: end-of-burst marker per requester. Present only with `MUX_ARB_LOCK_EN`.
- `req_ready`, output, 8: per-requester ready; at most one bit set.
- `sel`, output, 3: mux select, index of the current or most recent grantee.
- `grant`, output, 8: one-hot grant; all zero when idle.
- `out_valid`, output, 1: output register holds a word.
- `out_data`, output, DW: output word.
- `out_ready`, input, 1: downstream accepts the word.
- `busy`, output, 1: high in GRANT state.

## Operation
- State machine with two states:
  - IDLE: `grant`=0 and `req_ready`=0. If `req_valid`≠0, pick the winner w, set `sel`<=w and `grant`<=onehot(w), and go to GRANT.
  - GRANT: `req_ready[sel]` = !`out_valid` || `out_ready`. A beat is accepted when `req_valid[sel]` && `req_ready[sel]`; on acceptance, `out_data`<=data[sel] and `out_valid`<=1.
- Release:
  - Without the lock feature: the first accepted beat releases the grant. The state returns to IDLE and `ptr`<=sel+1 (3-bit, wraps 7→0).
- Winner search: scan indices `ptr`, `ptr`+1, …, `ptr`+7 modulo 8, and take the first index with `req_valid` set.
- `ptr` changes only on release.
- Output register:
  - `out_valid` clears on `out_ready` when no new beat is accepted in the same cycle.
  - When a beat is accepted in the same cycle as `out_ready`, `out_valid` stays 1 and `out_data` takes the new word.
- `sel` holds its value in IDLE; it is never forced to 0 except by reset.
- Requester rule: a granted requester must not drop `req_valid` before its beat is accepted. The block does not recover from this violation; it stays in GRANT.

## Timing
- Reset values: state=IDLE, `ptr`=0, `sel`=0, `grant`=0, `req_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0. All take effect immediately on `rst_n` low, with no clock required.
- Arbitration latency:
  - Requests are sampled in IDLE at edge k; `grant`, `sel` and `busy` are valid after edge k.
  - `req_ready` can rise in cycle k+1 and the beat can be accepted at edge k+1.
  - `out_valid` is high after edge k+1.
- Throughput: at most one single-beat grant every 2 cycles when `out_ready`=1.
- `req_ready` is combinational from state, `sel`, `out_valid` and `out_ready`. It has no combinational path from `req_valid`.
- Arbitration in IDLE proceeds even while `out_valid`=1. Backpressure applies only in GRANT, through `req_ready`.
- If `rst_n` is asserted mid-burst or with a word held, the word is dropped and all state returns to reset values.

## Configuration
- `MUX_ARB_LOCK_EN`: burst lock.
- Defined:
  - The `req_last` port exists.
  - In GRANT, the grant is held across accepted beats and released only on an accepted beat with `req_last[sel]`=1; `ptr` then advances.
  - Gaps with `req_valid[sel]`=0 keep the grant.
- Undefined:
  - The `req_last` port is absent.
  - Every accepted beat releases the grant.

## Structure
- Package `mux8_arb_pkg` contains:
  - `N_REQ`=8 and `SEL_W`=3.
  - Enum `arb_state_t` {IDLE, GRANT}.
  - Function `onehot8(sel)`.
- Sub-module `rr_pick8`: combinational rotate-priority picker.
  - Inputs: 8-bit request vector and 3-bit `ptr`.
  - Outputs: 3-bit winner index and an `any` flag.

## Test plan
- Reset: hold `rst_n`=0 with random inputs, then release. Required: all outputs 0 and `sel`=0; the first lone `req_valid`=8'h20 gives `sel`=5 and `grant`=8'h20 one cycle later.
- Fairness: hold `req_valid`=8'hFF with `out_ready`=1 and `ptr`=0. Required: the grant order is 0,1,2,…,7,0, with one beat every 2 cycles.
- Wrap-around: `ptr`=7 (after serving 6), then `req_valid`=8'h81. Required: 7 wins, then 0.
- Backpressure: grant requester 3, `out_ready`=0, with `out_valid` already 1. Required: `req_ready[3]`=0 and `out_data` is stable. Raising `out_ready` accepts the new word in the same cycle with `out_valid` held at 1.
- Lock (`MUX_ARB_LOCK_EN`): requester 2 sends 4 beats with `last` on the 4th, a `req_valid[2]` gap of 2 cycles, and requester 4 requesting throughout. Required: the grant is held on 2 for all 4 beats, then moves to 4.
- Reset mid-operation: assert `rst_n`=0 in GRANT with `out_valid`=1. Required: immediate return to IDLE with `out_valid`=0 and `ptr`=0.
